gain_matrix_mac: RTL

//  Parametrised fixed-point matrix-vector multiplier for the controller loop: u = K * x.

---
 rtl/gain_matrix_mac_pkg.sv | 31 +++
 rtl/gain_matrix_mac_mac_sat_unit.sv | 38 +++
 rtl/gain_matrix_mac.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/gain_matrix_mac_pkg.sv
// Shared types and fixed-point helpers for the gain matrix MAC.
// sat_round works on a wide signed value so any ACC_W up to SAT_W fits.
package gain_matrix_mac_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_TICK, COMPUTE, OUTPUT} state_t;

  localparam int unsigned SAT_W = 128;

  // Round half-up at frac_w, then clamp to a signed data_w range.
  function automatic logic signed [SAT_W-1:0] sat_round(
    input logic signed [SAT_W-1:0] acc,
    input int unsigned             data_w,
    input int unsigned             frac_w
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] rnd;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = SAT_W'(1);
    rnd = (acc + (one <<< (frac_w - 1))) >>> frac_w;
    hi  = (one <<< (data_w - 1)) - one;
    lo  = ~hi;
    if (rnd > hi) begin
      return hi;
    end else if (rnd < lo) begin
      return lo;
    end
    return rnd;
  endfunction

endpackage

// File: rtl/gain_matrix_mac_mac_sat_unit.sv
// Serial multiply-accumulate lane with a saturating, rounded result tap.
module mac_sat_unit
  import gain_matrix_mac_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FRAC_W = 16,
  parameter int unsigned ACC_W  = 68
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     first,
  input  logic signed [DATA_W-1:0] k,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] result_c
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  base_c;
  logic signed [ACC_W-1:0]  acc_next_c;
  logic signed [ACC_W-1:0]  acc_q;

  assign prod_c     = PROD_W'(k) * PROD_W'(x);
  assign base_c     = first ? '0 : acc_q;
  assign acc_next_c = base_c + ACC_W'(prod_c);
  assign result_c   = DATA_W'(sat_round(SAT_W'(acc_next_c), DATA_W, FRAC_W));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_next_c;
    end
  end

endmodule

// File: rtl/gain_matrix_mac.sv
// Paced fixed-point u = K * x with double-buffered gains and one serial MAC lane.
// Sample overruns are flagged sticky until reset.
module gain_matrix_mac
  import gain_matrix_mac_pkg::*;
#(
  parameter  int unsigned ROWS   = 3,
  parameter  int unsigned COLS   = 11,
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned FRAC_W = 16,
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     gain_wr_en,
  input  logic [ROW_W-1:0]         gain_wr_row,
  input  logic [COL_W-1:0]         gain_wr_col,
  input  logic [DATA_W-1:0]        gain_wr_data,
  input  logic                     gain_commit,
  input  logic [31:0]              sample_time,
  input  logic                     state_valid,
  output logic                     state_ready,
  input  logic [COLS*DATA_W-1:0]   state_vector,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROWS*DATA_W-1:0]   out_vector,
  output logic                     busy,
  output logic                     overrun
);

  localparam int unsigned ACC_W = 2 * DATA_W + $clog2(COLS);

  state_t                   state_q;
  logic [ROW_W-1:0]         row_q;
  logic [COL_W-1:0]         col_q;
  logic [31:0]              count_q;
  logic                     commit_pend_q;
  logic signed [DATA_W-1:0] shadow_q [ROWS][COLS];
  logic signed [DATA_W-1:0] active_q [ROWS][COLS];
  logic signed [DATA_W-1:0] x_q      [COLS];
  logic signed [DATA_W-1:0] u_q      [ROWS];
  logic signed [DATA_W-1:0] result_c;
  logic                     tick_c;
  logic                     start_c;
  logic                     wr_ok_c;
  logic                     row_last_c;
  logic                     col_last_c;

  assign tick_c     = (sample_time != 32'd0) && (count_q >= sample_time - 32'd1);
  assign start_c    = ((state_q == IDLE) && state_valid && (sample_time == 32'd0)) ||
                      ((state_q == WAIT_TICK) && tick_c);
  assign wr_ok_c    = gain_wr_en && (32'(gain_wr_row) < ROWS) && (32'(gain_wr_col) < COLS);
  assign row_last_c = (row_q == ROW_W'(ROWS - 1));
  assign col_last_c = (col_q == COL_W'(COLS - 1));

  for (genvar r = 0; r < ROWS; r++) begin : g_out
    assign out_vector[r*DATA_W +: DATA_W] = u_q[r];
  end

  mac_sat_unit #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clock    (clock),
    .reset    (reset),
    .en       (state_q == COMPUTE),
    .first    (col_q == '0),
    .k        (active_q[row_q][col_q]),
    .x        (x_q[col_q]),
    .result_c (result_c)
  );

  // Period timer: free-running, wraps on every tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= tick_c ? 32'd0 : count_q + 32'd1;
    end
  end

  // Gain banks; the copy at compute start sees the pre-write shadow contents.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      commit_pend_q <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          shadow_q[r][c] <= '0;
          active_q[r][c] <= '0;
        end
      end
    end else begin
      if (wr_ok_c) begin
        shadow_q[gain_wr_row][gain_wr_col] <= gain_wr_data;
      end
      if (start_c && (commit_pend_q || gain_commit)) begin
        active_q      <= shadow_q;
        commit_pend_q <= 1'b0;
      end else if (gain_commit) begin
        commit_pend_q <= 1'b1;
      end
    end
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      state_ready <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      for (int c = 0; c < COLS; c++) x_q[c] <= '0;
      for (int r = 0; r < ROWS; r++) u_q[r] <= '0;
    end else begin
      if (tick_c && ((state_q == COMPUTE) || (state_q == OUTPUT))) begin
        overrun <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (state_valid) begin
            for (int c = 0; c < COLS; c++) x_q[c] <= state_vector[c*DATA_W +: DATA_W];
            row_q       <= '0;
            col_q       <= '0;
            state_ready <= 1'b0;
            busy        <= 1'b1;
            state_q     <= start_c ? COMPUTE : WAIT_TICK;
          end
        end
        WAIT_TICK: begin
          if (tick_c) state_q <= COMPUTE;
        end
        COMPUTE: begin
          if (col_last_c) begin
            u_q[row_q] <= result_c;
            col_q      <= '0;
            if (row_last_c) begin
              row_q   <= '0;
              state_q <= OUTPUT;
            end else begin
              row_q <= row_q + ROW_W'(1);
            end
          end else begin
            col_q <= col_q + COL_W'(1);
          end
        end
        OUTPUT: begin
          // out_valid rises one cycle after entry so the last row has settled.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid   <= 1'b0;
            state_ready <= 1'b1;
            busy        <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
